pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_branch_unit_if.sv | 27 ++
 rtl/pc_target_mux.sv | 40 ++++
 rtl/pc_branch_unit.sv | 82 ++++++++
 tb/tb_pc_branch_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC width, default sequential step, fetch FSM states.
package cpu_pkg;
  localparam int PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t DEFAULT_PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } pc_state_e;

  // Address arithmetic always wraps at the PC width.
  function automatic pc_t pc_add(input pc_t a, input pc_t b);
    return a + b;
  endfunction
endpackage

// File: rtl/pc_branch_unit_if.sv
// Fetch-control bus between the pipeline (master) and the PC/branch unit (slave).
interface pc_branch_unit_if;
  import cpu_pkg::*;

  logic stall;
  logic br_taken;
  pc_t  br_base;
  pc_t  br_offset;
  logic jmp_valid;
  pc_t  jmp_target;
  logic imem_ready;
  pc_t  pc;
  logic pc_valid;
  pc_t  pc_link;
  logic flush;
  logic misalign_err;

  modport master (
    output stall, br_taken, br_base, br_offset, jmp_valid, jmp_target, imem_ready,
    input  pc, pc_valid, pc_link, flush, misalign_err
  );

  modport slave (
    input  stall, br_taken, br_base, br_offset, jmp_valid, jmp_target, imem_ready,
    output pc, pc_valid, pc_link, flush, misalign_err
  );
endinterface

// File: rtl/pc_target_mux.sv
// Combinational next-PC select: redirect target (branch beats jump) > sequential step > hold.
// PC_ALIGN_CHECK_EN: odd targets are rejected (flagged) instead of having bit 0 cleared.
module pc_target_mux
  import cpu_pkg::*;
#(
  parameter pc_t PC_STEP = DEFAULT_PC_STEP
) (
  input  pc_t  pc,
  input  logic advance,
  input  logic br_taken,
  input  pc_t  br_base,
  input  pc_t  br_offset,
  input  logic jmp_valid,
  input  pc_t  jmp_target,
  output pc_t  next_pc,
  output logic redirect,
  output logic misalign
);
  pc_t  raw_target;
  pc_t  target;
  logic want;

  assign raw_target = br_taken ? pc_add(br_base, br_offset) : jmp_target;
  assign want       = br_taken | jmp_valid;

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = want & raw_target[0];
  assign redirect = want & ~raw_target[0];
  assign target   = raw_target;
`else
  assign misalign = 1'b0;
  assign redirect = want;
  assign target   = raw_target & ~pc_t'(1);
`endif

  // A rejected odd target leaves pc untouched, even if a fetch would have advanced.
  assign next_pc = redirect ? target :
                   misalign ? pc :
                   advance  ? pc_add(pc, PC_STEP) : pc;
endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register and IDLE/FETCH/REDIRECT control; redirects squash one fetch slot.
// Optional macro PC_ALIGN_CHECK_EN enables odd-target rejection with misalign_err.
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = 16'h0000,
  parameter pc_t PC_STEP  = DEFAULT_PC_STEP
) (
  input logic             clk,
  input logic             reset,
  pc_branch_unit_if.slave bus
);
  pc_state_e state_q;
  pc_t       pc_q;
  logic      pc_valid_q;
  logic      flush_q;
  logic      err_q;

  pc_t  next_pc;
  logic redirect;
  logic misalign;
  logic advance;

  assign advance = pc_valid_q & bus.imem_ready & ~bus.stall;

  pc_target_mux #(.PC_STEP(PC_STEP)) u_mux (
    .pc         (pc_q),
    .advance    (advance),
    .br_taken   (bus.br_taken),
    .br_base    (bus.br_base),
    .br_offset  (bus.br_offset),
    .jmp_valid  (bus.jmp_valid),
    .jmp_target (bus.jmp_target),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Redirect requests are ignored until fetching has started.
          state_q    <= FETCH;
          pc_valid_q <= 1'b1;
          flush_q    <= 1'b0;
        end
        FETCH, REDIRECT: begin
          pc_q  <= next_pc;
          err_q <= misalign;
          if (redirect) begin
            state_q    <= REDIRECT;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b1;
          end else begin
            state_q    <= FETCH;
            pc_valid_q <= 1'b1;
            flush_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          pc_valid_q <= 1'b0;
          flush_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_err = err_q;
  assign bus.pc_link      = pc_add(pc_q, PC_STEP);
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vectors for pc_branch_unit; expectations queued by the driver, checked by a monitor.
module tb_pc_branch_unit;
  import cpu_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic        vld;
    logic        fl;
    logic        err;
    logic [15:0] link;
  } exp_t;

  logic clk;
  logic reset;
  pc_branch_unit_if bus();

  pc_branch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 0;

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_sample cyc=%0d: expectation never sampled (now cyc %0d)", e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.pc !== e.pc || bus.pc_valid !== e.vld || bus.flush !== e.fl ||
            bus.misalign_err !== e.err || bus.pc_link !== e.link) begin
          n_bad++;
          $display("FAIL step_cyc%0d: got pc=%h vld=%b flush=%b err=%b link=%h, want pc=%h vld=%b flush=%b err=%b link=%h",
                   cyc, bus.pc, bus.pc_valid, bus.flush, bus.misalign_err, bus.pc_link,
                   e.pc, e.vld, e.fl, e.err, e.link);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic bt,
                      input logic [15:0] bb, input logic [15:0] bo,
                      input logic jv, input logic [15:0] jt, input logic rdy,
                      input logic [15:0] e_pc, input logic e_vld,
                      input logic e_fl, input logic e_err);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.stall      = st;
    bus.br_taken   = bt;
    bus.br_base    = bb;
    bus.br_offset  = bo;
    bus.jmp_valid  = jv;
    bus.jmp_target = jt;
    bus.imem_ready = rdy;
    e.cyc  = cyc + 1;
    e.pc   = e_pc;
    e.vld  = e_vld;
    e.fl   = e_fl;
    e.err  = e_err;
    e.link = e_pc + 16'd2;
    q.push_back(e);
  endtask

  initial begin
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_base    = '0;
    bus.br_offset  = '0;
    bus.jmp_valid  = 1'b0;
    bus.jmp_target = '0;
    bus.imem_ready = 1'b0;

    // Reset held 3 cycles
    //   rst st bt  base     off      jv  target   rdy  e_pc     vld fl err
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // IDLE -> FETCH, then sequential fetch
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 0, 0);
    // Backward branch 0x0010 + (-8)
    step(0, 0, 1, 16'h0010, 16'hFFF8, 0, 16'h0000, 1, 16'h0008, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h000A, 1, 0, 0);
    // Branch beats jump, redirect beats stall
    step(0, 1, 1, 16'h0020, 16'h0004, 1, 16'h0100, 1, 16'h0024, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0024, 1, 0, 0);
    // Jump, then a second jump while in REDIRECT
    step(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 1, 16'h0100, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hFFFE, 1, 16'hFFFE, 0, 1, 0);
    // Hold at 0xFFFE while imem not ready, then wrap
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'hFFFE, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'hFFFE, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'hFFFE, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
    // Stall holds
    step(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 0, 0);
    // Odd jump target
`ifdef PC_ALIGN_CHECK_EN
    step(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0033, 1, 16'h0002, 1, 0, 1);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 0, 0);
`else
    step(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0033, 1, 16'h0032, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0032, 1, 0, 0);
`endif
    // Reset, and jump ignored in IDLE
    step(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 1, 16'h0000, 1, 0, 0);
    // Reset overrides a pending redirect
    step(0, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 1, 0);
    step(1, 0, 1, 16'h0040, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
    // Branch target wraps past 0xFFFF
    step(0, 0, 1, 16'hFFF0, 16'h0020, 0, 16'h0000, 1, 16'h0010, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0010, 1, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
    end
    done = 1;
  end

  initial begin
    fork
      wait (done);
      begin
        #20000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: run not complete at time %0t, want completion", $time);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
